// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - address fields, FSM states and line pack/unpack helpers for the data cache
package cache_pkg;

  localparam int ADDR_W = 10;
  localparam int TAG_W  = 4;
  localparam int IDX_W  = 2;
  localparam int WORD_W = 2;
  localparam int LINES  = 4;
  localparam int WORDS  = 4;
  localparam int LINE_W = 32 * WORDS;

  typedef enum logic [1:0] {IDLE, COMPARE, ALLOCATE, WRITE_THROUGH} state_t;

  typedef logic [WORDS-1:0][31:0] line_t;

  function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W-1:0] addr);
    return TAG_W'(addr >> (ADDR_W - TAG_W));
  endfunction

  function automatic logic [IDX_W-1:0] addr_idx(input logic [ADDR_W-1:0] addr);
    return IDX_W'(addr >> (WORD_W + 2));
  endfunction

  function automatic logic [WORD_W-1:0] addr_word(input logic [ADDR_W-1:0] addr);
    return WORD_W'(addr >> 2);
  endfunction

  // Word 0 sits in the least significant 32 bits of the flat line image.
  function automatic logic [LINE_W-1:0] pack_line(input line_t line);
    logic [LINE_W-1:0] flat;
    flat = '0;
    for (int w = 0; w < WORDS; w++) flat[32*w +: 32] = line[w];
    return flat;
  endfunction

  function automatic line_t unpack_line(input logic [LINE_W-1:0] flat);
    line_t line;
    line = '0;
    for (int w = 0; w < WORDS; w++) line[w] = flat[32*w +: 32];
    return line;
  endfunction

endpackage

// File: rtl/cache_line_store.sv
// rtl/cache_line_store.sv - 4x4x32 cache data array with word and full-line write ports
module cache_line_store
  import cache_pkg::*;
(
  input  logic              clk,
  input  logic [IDX_W-1:0]  idx,
  input  logic [WORD_W-1:0] word,
  input  logic              word_we,
  input  logic [31:0]       word_wdata,
  input  logic              line_we,
  input  logic [LINE_W-1:0] line_wdata,
  output logic [31:0]       word_rdata,
  output logic [LINE_W-1:0] line_rdata
);

  line_t lines [LINES];

  // A fill never coincides with a store, so the line port simply takes priority.
  always_ff @(posedge clk) begin
    if (line_we) begin
      lines[idx] <= unpack_line(line_wdata);
    end else if (word_we) begin
      lines[idx][word] <= word_wdata;
    end
  end

  assign word_rdata = lines[idx][word];
  assign line_rdata = pack_line(lines[idx]);

endmodule

// File: rtl/cache_controller.sv
// rtl/cache_controller.sv - blocking direct-mapped write-through/write-allocate cache controller
module cache_controller
  import cache_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cpu_req,
  input  logic             cpu_we,
  input  logic [9:0]       cpu_addr,
  input  logic [31:0]      cpu_wdata,
  output logic [31:0]      cpu_rdata,
  output logic             cpu_ready,
  output logic             cpu_hit,
  output logic             mem_req,
  output logic             mem_we,
  output logic [9:0]       mem_addr,
  output logic [127:0]     mem_wdata,
  input  logic [127:0]     mem_rdata,
  input  logic             mem_ready,
  output logic [CNT_W-1:0] hit_count,
  output logic [CNT_W-1:0] miss_count
);

  state_t state, state_next;

  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic [TAG_W-1:0]  req_tag;
  logic [IDX_W-1:0]  req_idx;
  logic [WORD_W-1:0] req_word;
  logic              first_cmp;
  logic              wt_done;
  logic [LINES-1:0]  valid;
  logic [TAG_W-1:0]  tags [LINES];
  logic              hit;

  logic              accept, read_done, word_we, line_we, wt_fire;
  logic [31:0]       word_rdata;
  logic [LINE_W-1:0] line_rdata;
  line_t             merged;

  assign req_tag  = addr_tag(req_addr);
  assign req_idx  = addr_idx(req_addr);
  assign req_word = addr_word(req_addr);
  assign hit      = valid[req_idx] && (tags[req_idx] == req_tag);

  cache_line_store u_store (
    .clk        (clk),
    .idx        (req_idx),
    .word       (req_word),
    .word_we    (word_we),
    .word_wdata (req_wdata),
    .line_we    (line_we),
    .line_wdata (mem_rdata),
    .word_rdata (word_rdata),
    .line_rdata (line_rdata)
  );

  // Write-through image: the stored line with the store word already merged in.
  always_comb begin
    merged = unpack_line(line_rdata);
    merged[req_word] = req_wdata;
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:          if (cpu_req) state_next = COMPARE;
      COMPARE: begin
        if (!hit)        state_next = ALLOCATE;
        else if (req_we) state_next = WRITE_THROUGH;
        else             state_next = IDLE;
      end
      ALLOCATE:      if (mem_ready) state_next = COMPARE;
      WRITE_THROUGH: if (mem_ready) state_next = IDLE;
      default:       state_next = IDLE;
    endcase
  end

  always_comb begin
    accept    = 1'b0;
    read_done = 1'b0;
    word_we   = 1'b0;
    line_we   = 1'b0;
    wt_fire   = 1'b0;
    case (state)
      IDLE:          accept = cpu_req;
      COMPARE: begin
        read_done = hit && !req_we;
        word_we   = hit && req_we;
      end
      ALLOCATE:      line_we = mem_ready;
      WRITE_THROUGH: wt_fire = mem_ready;
      default: ;
    endcase
  end

  // Stores complete one cycle after the write-through handshake, from IDLE.
  assign cpu_ready = read_done | wt_done;
  assign cpu_hit   = cpu_ready & first_cmp;
  assign cpu_rdata = cpu_ready ? word_rdata : 32'd0;

  always_ff @(posedge clk) begin
    if (reset) begin
      req_we     <= 1'b0;
      req_addr   <= '0;
      req_wdata  <= '0;
      first_cmp  <= 1'b0;
      wt_done    <= 1'b0;
      valid      <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      wt_done <= wt_fire;
      if (accept) begin
        req_we    <= cpu_we;
        req_addr  <= cpu_addr;
        req_wdata <= cpu_wdata;
        first_cmp <= 1'b1;
      end
      if (state == COMPARE) begin
        if (!hit) begin
          first_cmp <= 1'b0;
          mem_req   <= 1'b1;
          mem_we    <= 1'b0;
          mem_addr  <= {req_addr[9:4], 4'b0000};
        end else if (req_we) begin
          mem_req   <= 1'b1;
          mem_we    <= 1'b1;
          mem_addr  <= {req_addr[9:4], 4'b0000};
          mem_wdata <= pack_line(merged);
        end
      end
      if (line_we) valid[req_idx] <= 1'b1;
      if (line_we || wt_fire) mem_req <= 1'b0;
      if (cpu_ready) begin
        if (cpu_hit) begin
          if (hit_count != '1) hit_count <= hit_count + 1'b1;
        end else begin
          if (miss_count != '1) miss_count <= miss_count + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (line_we) tags[req_idx] <= req_tag;
  end

endmodule

// File: doc/cache_controller.md
# cache_controller

Blocking controller for the direct-mapped, write-through, write-allocate data cache: 10-bit byte address, 4 lines × 4 words × 32 bits. It accepts one CPU access at a time, performs the tag compare, and sequences line fills and write-through transfers to the block-wide main memory over a req/ready handshake. It sits between the CPU load/store path and the `Memory` block, owns the valid/tag/data arrays, and keeps hit/miss statistics.

## Interface
Parameters:
- `CNT_W`, default 16: width of the hit and miss counters.

Ports:
- `clk`  in  1  single clock; everything samples on its rising edge.
- `reset`  in  1  synchronous, active-high.
- `cpu_req`  in  1  access request; sampled only in IDLE.
- `cpu_we`  in  1  1 = store, 0 = load.
- `cpu_addr`  in  10  byte address: tag [9:6], index [5:4], word [3:2], byte [1:0] (byte bits ignored).
- `cpu_wdata`  in  32  store data.
- `cpu_rdata`  out  32  load data; valid while `cpu_ready` = 1.
- `cpu_ready`  out  1  one-cycle completion pulse.
- `cpu_hit`  out  1  qualifies `cpu_ready`: 1 if the access hit on its first compare.
- `mem_req`  out  1  memory transfer request.
- `mem_we`  out  1  1 = block write, 0 = block read.
- `mem_addr`  out  10  block-aligned address, with [3:0] = 0.
- `mem_wdata`  out  128  line image; word0 in [31:0] through word3 in [127:96].
- `mem_rdata`  in  128  fill data; same word ordering.
- `mem_ready`  in  1  memory completion pulse.
- `hit_count`, `miss_count`  out  CNT_W  saturating statistics.

## Operation
- State IDLE: when `cpu_req` = 1, latch `cpu_we`, `cpu_addr` and `cpu_wdata`, then go to COMPARE. CPU inputs are ignored in every other state.
- State COMPARE: hit means `valid[idx]` && `tag[idx]` == the latched tag.
  - Read hit: `cpu_rdata` = `line[idx][word]`, `cpu_ready` = 1, go to IDLE.
  - Write hit: update `line[idx][word]`, go to WRITE_THROUGH.
  - Miss: go to ALLOCATE. The "first compare" flag is cleared so the final `cpu_hit` = 0.
- State ALLOCATE: drive `mem_req` = 1, `mem_we` = 0, `mem_addr` = {tag, idx, 4'b0}. On `mem_ready`, write all 4 words from `mem_rdata`, set `valid[idx]` = 1 and `tag[idx]` = the latched tag, then return to COMPARE, which now hits and completes the access.
- State WRITE_THROUGH: drive `mem_req` = 1, `mem_we` = 1, `mem_addr` = block address, `mem_wdata` = the updated line. On `mem_ready`, pulse `cpu_ready` and go to IDLE.
- Counters: exactly one counter increments per access, in the cycle `cpu_ready` pulses: `hit_count` if `cpu_hit` = 1, otherwise `miss_count`. Each saturates at all-ones.

## Timing
- Reset values: all outputs 0, including `mem_addr`, `mem_wdata`, `cpu_rdata` and both counters. Reset also clears every valid bit and leaves the FSM in IDLE. Data and tag arrays need no reset.
- Read hit: request sampled at edge N, `cpu_ready` high during cycle N+1, back in IDLE at N+2.
- Memory handshake:
  - `mem_req`, `mem_we`, `mem_addr` and `mem_wdata` are registered and stay stable while `mem_req` = 1.
  - The transfer completes on the first edge that samples `mem_ready` = 1; `mem_req` is low in the following cycle.
  - `mem_ready` is ignored outside ALLOCATE and WRITE_THROUGH.
  - Memory latency is arbitrary, zero wait states included (ready in the first req cycle).
- Read miss: `cpu_ready` pulses 1 cycle after the fill completes (the re-COMPARE cycle).
- Write hit: `cpu_ready` pulses in the cycle after the write-through `mem_ready` is sampled.
- Write miss: ALLOCATE → COMPARE → WRITE_THROUGH → ready, so two memory transactions.
- `cpu_req` held high in IDLE starts a new access every time IDLE is re-entered; back-to-back accesses are allowed.
- Reset during any state: the next cycle is IDLE with `mem_req` = 0, and any in-flight memory transfer is abandoned. A fill aborted before `mem_ready` leaves its line invalid.

## Structure
- Package `cache_pkg`:
  - field widths/positions: TAG_W = 4, IDX_W = 2, WORD_W = 2, LINES = 4, WORDS = 4;
  - state enum {IDLE, COMPARE, ALLOCATE, WRITE_THROUGH};
  - tag/index/word extraction functions;
  - line pack/unpack functions following the 128-bit word ordering.
- Sub-module `cache_line_store`:
  - the 4×4×32 data array, one word-write port, one full-line write port, a combinational word read and a full-line read;
  - valid, tag, FSM and counters stay in `cache_controller`.

## Test plan
- Cold read of 0x3A4 with memory at block 0x3A0 = {D3, D2, D1, D0} → one read at `mem_addr` 0x3A0; `cpu_rdata` = D1, `cpu_hit` = 0, `miss_count` = 1.
- Repeat the read of 0x3A4 → no `mem_req`; `cpu_ready` in cycle N+1, `cpu_rdata` = D1, `cpu_hit` = 1, `hit_count` = 1.
- Store 0xDEADBEEF to 0x3AC (hit) → one write, `mem_wdata` = {0xDEADBEEF, D2, D1, D0}; a following load of 0x3AC returns 0xDEADBEEF.
- Store to 0x0E8 (miss, index 2) with memory latency 5 → a read of 0x0E0, then a write of 0x0E0 with word2 replaced; a conflicting load of 0x1E8 then misses and refills index 2.
- Assert `reset` while ALLOCATE waits on `mem_ready` → next cycle `mem_req` = 0 and IDLE; a re-read of the same address misses again.
- Zero-wait memory (`mem_ready` in the first req cycle) plus `cpu_req` held high for 4 loads → all four complete, `mem_req` is never high for more than 1 cycle, and the counters sum to 4.
